// File: rtl/expr_pkg.sv
// Shared types and character constants for the expression evaluator.
package expr_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_OPND  = 2'd1,
        S_OPR   = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;

endpackage

// File: rtl/char_classify.sv
// Combinational ASCII classifier shared by the string checker and the evaluator.
module char_classify
    import expr_pkg::*;
(
    input  logic [7:0] in,
    output logic       is_digit,
    output logic       is_plus,
    output logic       is_mul,
    output logic [3:0] dval
);

    // Decode the character class; '0'..'9' carry their value in the low nibble.
    always_comb begin
        is_digit = (in >= CH_0) && (in <= CH_9);
        is_plus  = (in == CH_PLUS);
        is_mul   = (in == CH_MUL);
        dval     = is_digit ? in[3:0] : 4'd0;
    end

endmodule

// File: rtl/expr_eval.sv
// Byte-serial evaluator for digit (op digit)* with '*' binding tighter than '+'.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | nothing accepted since reset/start
// S_OPND  | last char was a digit; expression is complete and legal
// S_OPR   | last char was an operator; waiting for its right operand
// S_ERR   | syntax error seen; absorbing until clr or start
module expr_eval
    import expr_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in,
    output logic [W-1:0] result,
    output logic         legal,
    output logic         err
);

    state_t       state_q, state_d;
    logic [W-1:0] sum_q, sum_d;
    logic [W-1:0] term_q, term_d;
    logic         mul_q, mul_d;

    logic         is_digit, is_plus, is_mul;
    logic [3:0]   dval;
    logic [W-1:0] dval_w;
    logic [W-1:0] prod;

    char_classify u_class (
        .in       (in),
        .is_digit (is_digit),
        .is_plus  (is_plus),
        .is_mul   (is_mul),
        .dval     (dval)
    );

    // The low W bits of term*d depend only on the low W bits of the operands,
    // so the truncated product is formed directly at W bits.
    always_comb begin
        dval_w = W'(dval);
        prod   = term_q * dval_w;
    end

    // Next-state and datapath update; registers hold unless a char is accepted.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        term_d  = term_q;
        mul_d   = mul_q;
        if (start) begin
            state_d = S_EMPTY;
            sum_d   = '0;
            term_d  = '0;
            mul_d   = 1'b0;
        end else if (in_valid) begin
            unique case (state_q)
                S_EMPTY: begin
                    if (is_digit) begin
                        term_d  = dval_w;
                        mul_d   = 1'b0;
                        state_d = S_OPND;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_OPND: begin
                    if (is_plus) begin
                        sum_d   = sum_q + term_q;
                        term_d  = '0;
                        mul_d   = 1'b0;
                        state_d = S_OPR;
                    end else if (is_mul) begin
                        mul_d   = 1'b1;
                        state_d = S_OPR;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_OPR: begin
                    if (is_digit) begin
                        term_d  = mul_q ? prod : dval_w;
                        state_d = S_OPND;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_ERR;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_EMPTY;
            sum_q   <= '0;
            term_q  <= '0;
            mul_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            term_q  <= term_d;
            mul_q   <= mul_d;
        end
    end

    // Outputs decode registers only.
    always_comb begin
        result = sum_q + term_q;
        legal  = (state_q == S_OPND);
        err    = (state_q == S_ERR);
    end

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval at W=16 and W=4 driven by the same stream.
module tb_expr_eval;

    logic        clk;
    logic        clr;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_ch;
    logic [15:0] result16;
    logic [3:0]  result4;
    logic        legal16, err16, legal4, err4;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] r16;
        logic [3:0]  r4;
        logic        legal;
        logic        err;
        logic        chk_r;
    } exp_t;

    exp_t sb[$];

    // reference model: 0 empty, 1 operand, 2 operator, 3 error
    int          m_state;
    int unsigned m_sum, m_term;
    bit          m_mul;

    expr_eval #(.W(16)) dut16 (
        .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in(in_ch),
        .result(result16), .legal(legal16), .err(err16)
    );

    expr_eval #(.W(4)) dut4 (
        .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in(in_ch),
        .result(result4), .legal(legal4), .err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_sum   = 0;
        m_term  = 0;
        m_mul   = 1'b0;
    endtask

    task automatic model_apply(input logic st, input logic v, input logic [7:0] c);
        bit dig;
        int unsigned d;
        dig = (c >= 8'h30) && (c <= 8'h39);
        d   = dig ? int'(c) - 32'h30 : 0;
        if (st) begin
            model_reset();
        end else if (v) begin
            case (m_state)
                0: if (dig) begin m_term = d; m_mul = 1'b0; m_state = 1; end
                   else m_state = 3;
                1: if (c == 8'h2B) begin
                       m_sum = m_sum + m_term; m_term = 0; m_mul = 1'b0; m_state = 2;
                   end else if (c == 8'h2A) begin
                       m_mul = 1'b1; m_state = 2;
                   end else m_state = 3;
                2: if (dig) begin
                       m_term = m_mul ? m_term * d : d; m_state = 1;
                   end else m_state = 3;
                default: m_state = 3;
            endcase
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        int unsigned r;
        r       = m_sum + m_term;
        e.r16   = r[15:0];
        e.r4    = r[3:0];
        e.legal = (m_state == 1);
        e.err   = (m_state == 3);
        e.chk_r = (m_state != 2);
        return e;
    endfunction

    task automatic compare_outputs(input string tag, input exp_t e);
        check({tag, ".legal16"}, 32'(legal16), 32'(e.legal));
        check({tag, ".err16"},   32'(err16),   32'(e.err));
        check({tag, ".legal4"},  32'(legal4),  32'(e.legal));
        check({tag, ".err4"},    32'(err4),    32'(e.err));
        if (e.chk_r) begin
            check({tag, ".result16"}, 32'(result16), 32'(e.r16));
            check({tag, ".result4"},  32'(result4),  32'(e.r4));
        end
    endtask

    task automatic step(input string tag, input logic st, input logic v, input logic [7:0] c);
        exp_t e;
        @(negedge clk);
        start    = st;
        in_valid = v;
        in_ch    = c;
        model_apply(st, v, c);
        sb.push_back(model_exp());
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            compare_outputs(tag, e);
        end
    endtask

    task automatic send_str(input string tag, input string s);
        for (int i = 0; i < s.len(); i++) begin
            step(tag, 1'b0, 1'b1, s[i]);
        end
    endtask

    initial begin
        clr      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_ch    = 8'h00;
        model_reset();
        #7;
        compare_outputs("reset", model_exp());
        check("reset.result16_zero", 32'(result16), 32'd0);
        @(negedge clk);
        clr = 1'b1;

        // 1+2*3 = 7; legal drops while an operator is pending
        send_str("t1", "1+2*");
        check("t1.legal_after_mul", 32'(legal16), 32'd0);
        send_str("t1", "3");
        check("t1.result7", 32'(result16), 32'd7);

        // 2*3*4+5 = 29 with two idle cycles after the second '*'
        step("t2.start", 1'b1, 1'b0, 8'h00);
        send_str("t2", "2*3*");
        step("t2.gap", 1'b0, 1'b0, "9");
        step("t2.gap", 1'b0, 1'b0, "+");
        send_str("t2", "4+5");
        check("t2.result29", 32'(result16), 32'd29);
        check("t2.result4_13", 32'(result4), 32'd13);

        // 1+2++3: error from the second '+', result frozen at 3
        step("t3.start", 1'b1, 1'b0, 8'h00);
        send_str("t3", "1+2++3");
        check("t3.err", 32'(err16), 32'd1);
        check("t3.frozen3", 32'(result16), 32'd3);

        // illegal first char, then start with a dropped '5', then '5'
        step("t4.start", 1'b1, 1'b0, 8'h00);
        send_str("t4", "a");
        step("t4.start_drop", 1'b1, 1'b1, "5");
        check("t4.empty_legal", 32'(legal16), 32'd0);
        check("t4.empty_result", 32'(result16), 32'd0);
        send_str("t4", "5");
        check("t4.result5", 32'(result16), 32'd5);

        // 9*9+1 = 82; wraps to 2 at W=4 with no error
        step("t5.start", 1'b1, 1'b0, 8'h00);
        send_str("t5", "9*9+1");
        check("t5.result82", 32'(result16), 32'd82);
        check("t5.w4_result2", 32'(result4), 32'd2);
        check("t5.w4_legal", 32'(legal4), 32'd1);

        // other illegal bytes: digit after digit, space
        step("t6.start", 1'b1, 1'b0, 8'h00);
        send_str("t6", "7 ");
        step("t6.start", 1'b1, 1'b0, 8'h00);
        send_str("t6", "3*45");

        // asynchronous clear between edges
        step("t7.start", 1'b1, 1'b0, 8'h00);
        send_str("t7", "1+2");
        #2;
        clr = 1'b0;
        #1;
        model_reset();
        sb.delete();
        check("t7.async_result", 32'(result16), 32'd0);
        check("t7.async_legal", 32'(legal16), 32'd0);
        check("t7.async_err", 32'(err16), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        send_str("t7", "8");
        check("t7.result8", 32'(result16), 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Downstream companion to the expression-string checker: consumes the same byte-serial ASCII stream (one character per accepted cycle) and evaluates it arithmetically.
- Grammar: digit (op digit)*, where digit is '0'..'9' (single-digit operands) and op is '+' or '*'.
- '*' binds tighter than '+'. Result is reported alongside a legal/error indication so the consumer can qualify it.

Parameters:
W, 16, result/accumulator width in bits; all arithmetic is modulo 2^W.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-low
- start  in  1  synchronous restart pulse; begins a new expression
- in_valid  in  1  qualifies in for one character per cycle
- in  in  8  ASCII character
- result  out  W  sum + term of the expression so far, mod 2^W
- legal  out  1  1 when the characters so far form a complete legal expression
- err  out  1  sticky syntax-error flag

Behaviour:
- Registers:
  - state in {S_EMPTY, S_OPND, S_OPR, S_ERR}
  - sum[W-1:0], term[W-1:0]
  - mul (1 = pending operator is '*')
- Outputs are combinational from registers only:
  - result = sum + term (truncated to W)
  - legal = (state == S_OPND)
  - err = (state == S_ERR)
- Reset (clr low, async): state = S_EMPTY, sum = 0, term = 0, mul = 0, so result = 0, legal = 0, err = 0.
- Reset asserted mid-expression discards all progress immediately, without waiting for a clock edge.
- start = 1 at an edge has the same effect as reset. It overrides in_valid in the same cycle, and that cycle's character is dropped.
- in_valid = 0: all registers hold.
- Latency: a character accepted at edge N is reflected in all outputs after edge N (zero extra cycles).
- Accepted character, by state:
  - S_EMPTY:
    - digit d → term = d, mul = 0, go to S_OPND
    - anything else → S_ERR
  - S_OPND:
    - '+' → sum = sum + term, term = 0, mul = 0, go to S_OPR
    - '*' → mul = 1, go to S_OPR
    - anything else (including a digit) → S_ERR
  - S_OPR:
    - digit d → term = mul ? term*d : d, go to S_OPND
    - anything else → S_ERR
  - S_ERR: absorbing. Only reset or start leaves it. sum/term freeze at their pre-error values.
- Arithmetic:
  - The product term*d is formed at W+4 bits and truncated to W.
  - All additions wrap mod 2^W.
  - No overflow flag.
- Digit value = in - 8'h30. Any byte outside 8'h30..8'h39, 8'h2B, 8'h2A is illegal, including spaces and control codes.
- result is meaningful only when legal = 1. In S_OPR it shows the partial value, which is permitted and must not be relied on.

Decomposition:
- Package expr_pkg:
  - state enum (S_EMPTY, S_OPND, S_OPR, S_ERR)
  - ASCII constants CH_0 = 8'h30, CH_9 = 8'h39, CH_PLUS = 8'h2B, CH_MUL = 8'h2A
- Sub-module char_classify (combinational):
  - input: in
  - outputs: is_digit, is_plus, is_mul, dval[3:0]
  - Shared with the checker so both stages agree on the character set.
- Remaining logic (FSM plus datapath) stays in expr_eval.

Test Plan:
- Reset then "1+2*3" one char per cycle → after last char: result = 7, legal = 1, err = 0. After '*': legal = 0.
- "2*3*4+5" with in_valid low for 2 cycles between '*' and '4' → result = 29, legal = 1. Outputs hold unchanged during the gaps.
- "1+2++3" → err = 1 from the second '+' onward. legal = 0, result frozen at 3. Subsequent '3' does not change anything.
- "a" as first char → err = 1. Then start pulse together with in_valid = 1, in = "5" → state S_EMPTY and '5' dropped. Then "5" → result = 5, legal = 1.
- W = 4: "9*9+1" → result = (81 + 1) mod 16 = 2, legal = 1. Wrap only, no error.
- Drive "1+2", then assert clr low between clock edges → result = 0, legal = 0, err = 0 before the next edge. Release, then "8" → result = 8.
